csr_trap_sequencer: RTL and testbench
=====================================

Name: csr_trap_sequencer

Overview:
Multi-cycle controller that owns the single write port and single read port of the machine-mode CSR file (mstatus, mtvec, mepc, mcause).
- Sequences the CSR updates for ecall-style traps and for mret.
- Arbitrates those updates against ordinary CSR-instruction writes from WBU and CSR reads from IDU.
- Produces the PC redirect for both cases.
- Sits between IDU/WBU and the CSR file; asserts a stall while a sequence runs.

Parameters:
BITS_W, 32, data width of CSRs and PCs
CSR_W, 12, CSR index width
IDX_MSTATUS, 0, CSR file index of mstatus
IDX_MTVEC, 1, CSR file index of mtvec
IDX_MEPC, 2, CSR file index of mepc
IDX_MCAUSE, 3, CSR file index of mcause

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wb_csr_valid  in  1  WBU CSR-instruction write request
wb_csr_rd  in  CSR_W  WBU write index
wb_csr_data  in  BITS_W  WBU write data
idu_csr_rs  in  CSR_W  IDU read index
idu_csr_rs_data  out  BITS_W  read data returned to IDU
trap_req  in  1  ecall/trap request pulse
trap_pc  in  BITS_W  PC of trapping instruction
trap_cause  in  BITS_W  mcause value
mret_req  in  1  mret request pulse
csr_wr_en  out  1  CSR file write enable
csr_wr_addr  out  CSR_W  CSR file write index
csr_wr_data  out  BITS_W  CSR file write data
csr_rd_addr  out  CSR_W  CSR file read index
csr_rd_data  in  BITS_W  CSR file combinational read data
busy  out  1  sequence in progress; pipeline stall
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  BITS_W  redirect target

Behaviour:
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTAT, T_VEC, M_STAT, M_EPC.
- busy = (state != IDLE), combinational.
- Reset: state=IDLE; latched pc/cause=0. Outputs csr_wr_en, redirect_valid, redirect_pc and busy are 0. Reset mid-sequence aborts immediately: no further writes, no redirect.
- IDLE:
  - csr_wr_en=wb_csr_valid, csr_wr_addr=wb_csr_rd, csr_wr_data=wb_csr_data.
  - csr_rd_addr=idu_csr_rs; idu_csr_rs_data=csr_rd_data.
  - trap_req → latch trap_pc and trap_cause, go to T_MEPC.
  - Else mret_req → go to M_STAT.
  - trap_req and mret_req in the same cycle: trap wins; mret dropped.
  - A WBU write in the same cycle as an accepted request is still performed that cycle; it is older.
- In non-IDLE states:
  - wb_csr_valid, trap_req and mret_req are ignored; upstream is stalled by busy.
  - idu_csr_rs_data is driven 0.
- T_MEPC: write mepc=latched pc → T_MCAUSE.
- T_MCAUSE: write mcause=latched cause → T_MSTAT.
- T_MSTAT:
  - rd_addr=mstatus; write mstatus = rd_data with bit7 (MPIE) := bit3 (MIE), bit3 := 0, bits[12:11] (MPP) := 2'b11; all other bits unchanged.
  - → T_VEC.
- T_VEC: rd_addr=mtvec; redirect_valid=1, redirect_pc = rd_data & ~3 (direct mode only) → IDLE.
- M_STAT:
  - rd_addr=mstatus; write mstatus = rd_data with bit3 := bit7, bit7 := 1, MPP := 2'b11 (M-only core).
  - → M_EPC.
- M_EPC: rd_addr=mepc; redirect_valid=1, redirect_pc=rd_data, no write → IDLE.
- Latency: trap accepted at cycle 0 gives writes at cycles 1–3, redirect at cycle 4, IDLE at cycle 5. mret gives a write at cycle 1, redirect at cycle 2.
- redirect_valid is high only in T_VEC/M_EPC and exactly one cycle per sequence. redirect_pc holds its last value otherwise.
- At most one CSR write per cycle. csr_wr_en=0 in T_VEC and M_EPC.

Test Plan:
1. After reset: busy=0, redirect_valid=0, csr_wr_en=0. WBU write idx1 data 0x80000400 in IDLE → csr_wr_en=1, addr=1, data=0x80000400 same cycle.
2. mstatus=0x1808; trap_req with pc=0x80000100, cause=0xb; mtvec=0x80000401 →
   - cycle1: mepc ← 0x80000100
   - cycle2: mcause ← 0xb
   - cycle3: mstatus ← 0x1880
   - cycle4: redirect_valid=1, redirect_pc=0x80000400
   - busy high cycles 1–4.
3. mstatus=0x1880, mepc=0x80000104; mret_req → cycle1 mstatus ← 0x1888; cycle2 redirect_pc=0x80000104; busy cycles 1–2.
4. trap_req and mret_req in the same cycle → trap sequence only; exactly one redirect, to mtvec.
5. wb_csr_valid, trap_req and mret_req pulsed during cycles 1–4 of a trap → no extra writes or redirects; IDU read data=0 while busy.
6. rst asserted at cycle 2 of a trap → next cycle IDLE, no mstatus write, no redirect; a following trap runs normally.

Source files
------------

// File: rtl/csr_trap_sequencer.sv
// Sequences machine-mode CSR updates for traps and mret, arbitrating the CSR
// file's single read and write ports against WBU writes and IDU reads.
`timescale 1ns/1ps
module csr_trap_sequencer #(
  parameter int unsigned BITS_W      = 32,
  parameter int unsigned CSR_W       = 12,
  parameter int unsigned IDX_MSTATUS = 0,
  parameter int unsigned IDX_MTVEC   = 1,
  parameter int unsigned IDX_MEPC    = 2,
  parameter int unsigned IDX_MCAUSE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_csr_valid,
  input  logic [CSR_W-1:0]  wb_csr_rd,
  input  logic [BITS_W-1:0] wb_csr_data,
  input  logic [CSR_W-1:0]  idu_csr_rs,
  output logic [BITS_W-1:0] idu_csr_rs_data,
  input  logic              trap_req,
  input  logic [BITS_W-1:0] trap_pc,
  input  logic [BITS_W-1:0] trap_cause,
  input  logic              mret_req,
  output logic              csr_wr_en,
  output logic [CSR_W-1:0]  csr_wr_addr,
  output logic [BITS_W-1:0] csr_wr_data,
  output logic [CSR_W-1:0]  csr_rd_addr,
  input  logic [BITS_W-1:0] csr_rd_data,
  output logic              busy,
  output logic              redirect_valid,
  output logic [BITS_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MSTAT, T_VEC, M_STAT, M_EPC
  } state_t;

  state_t            state;
  logic [BITS_W-1:0] pc_q;
  logic [BITS_W-1:0] cause_q;
  logic [BITS_W-1:0] redir_q;
  logic [BITS_W-1:0] trap_mstatus;
  logic [BITS_W-1:0] mret_mstatus;
  logic [BITS_W-1:0] vec_pc;

  // mstatus rewrites: trap stacks MIE into MPIE, mret restores it; MPP is always M.
  always_comb begin
    trap_mstatus        = csr_rd_data;
    trap_mstatus[7]     = csr_rd_data[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = csr_rd_data;
    mret_mstatus[3]     = csr_rd_data[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
    vec_pc              = csr_rd_data & ~BITS_W'(3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      redir_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            state   <= T_MEPC;
          end else if (mret_req) begin
            state <= M_STAT;
          end
        end
        T_MEPC:   state <= T_MCAUSE;
        T_MCAUSE: state <= T_MSTAT;
        T_MSTAT:  state <= T_VEC;
        T_VEC: begin
          redir_q <= vec_pc;
          state   <= IDLE;
        end
        M_STAT:   state <= M_EPC;
        M_EPC: begin
          redir_q <= csr_rd_data;
          state   <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Read address kept apart from the data-dependent outputs so the read path stays acyclic.
  always_comb begin
    csr_rd_addr = idu_csr_rs;
    case (state)
      T_MSTAT, M_STAT: csr_rd_addr = CSR_W'(IDX_MSTATUS);
      T_VEC:           csr_rd_addr = CSR_W'(IDX_MTVEC);
      M_EPC:           csr_rd_addr = CSR_W'(IDX_MEPC);
      default:         csr_rd_addr = idu_csr_rs;
    endcase
  end

  always_comb begin
    csr_wr_en       = 1'b0;
    csr_wr_addr     = wb_csr_rd;
    csr_wr_data     = wb_csr_data;
    idu_csr_rs_data = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = redir_q;
    case (state)
      IDLE: begin
        csr_wr_en       = wb_csr_valid;
        idu_csr_rs_data = csr_rd_data;
      end
      T_MEPC: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_W'(IDX_MEPC);
        csr_wr_data = pc_q;
      end
      T_MCAUSE: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_W'(IDX_MCAUSE);
        csr_wr_data = cause_q;
      end
      T_MSTAT: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_W'(IDX_MSTATUS);
        csr_wr_data = trap_mstatus;
      end
      T_VEC: begin
        redirect_valid = 1'b1;
        redirect_pc    = vec_pc;
      end
      M_STAT: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_W'(IDX_MSTATUS);
        csr_wr_data = mret_mstatus;
      end
      M_EPC: begin
        redirect_valid = 1'b1;
        redirect_pc    = csr_rd_data;
      end
      default: ;
    endcase
    // Reset aborts a sequence in the very cycle it is asserted.
    if (rst) begin
      csr_wr_en      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: a small CSR file plus a rule-level model of
// trap/mret effects, driven with directed and randomized sequences.
`timescale 1ns/1ps
module tb_csr_trap_sequencer;
  localparam int unsigned BITS_W      = 32;
  localparam int unsigned CSR_W       = 12;
  localparam int unsigned IDX_MSTATUS = 0;
  localparam int unsigned IDX_MTVEC   = 1;
  localparam int unsigned IDX_MEPC    = 2;
  localparam int unsigned IDX_MCAUSE  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_csr_valid;
  logic [CSR_W-1:0]  wb_csr_rd;
  logic [BITS_W-1:0] wb_csr_data;
  logic [CSR_W-1:0]  idu_csr_rs;
  logic [BITS_W-1:0] idu_csr_rs_data;
  logic              trap_req;
  logic [BITS_W-1:0] trap_pc;
  logic [BITS_W-1:0] trap_cause;
  logic              mret_req;
  logic              csr_wr_en;
  logic [CSR_W-1:0]  csr_wr_addr;
  logic [BITS_W-1:0] csr_wr_data;
  logic [CSR_W-1:0]  csr_rd_addr;
  logic [BITS_W-1:0] csr_rd_data;
  logic              busy;
  logic              redirect_valid;
  logic [BITS_W-1:0] redirect_pc;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_csr  [4];
  logic [31:0] csr_file [4];
  logic [31:0] last_rpc;

  csr_trap_sequencer #(
    .BITS_W(BITS_W), .CSR_W(CSR_W), .IDX_MSTATUS(IDX_MSTATUS),
    .IDX_MTVEC(IDX_MTVEC), .IDX_MEPC(IDX_MEPC), .IDX_MCAUSE(IDX_MCAUSE)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_csr_valid(wb_csr_valid), .wb_csr_rd(wb_csr_rd), .wb_csr_data(wb_csr_data),
    .idu_csr_rs(idu_csr_rs), .idu_csr_rs_data(idu_csr_rs_data),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_req(mret_req),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Four-entry CSR file: combinational read, write on the clock edge.
  assign csr_rd_data = (csr_rd_addr < CSR_W'(4)) ? csr_file[csr_rd_addr[1:0]] : '0;
  always @(posedge clk)
    if (csr_wr_en && csr_wr_addr < CSR_W'(4)) csr_file[csr_wr_addr[1:0]] <= csr_wr_data;

  function automatic logic [31:0] trap_ms(input logic [31:0] s);
    return (s & ~32'h0000_0088) | ((s & 32'h8) << 4) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] s);
    return (s & ~32'h0000_0008) | ((s & 32'h80) >> 4) | 32'h0000_1880;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wb_csr_valid = 1'b0;
    trap_req     = 1'b0;
    mret_req     = 1'b0;
    idu_csr_rs   = CSR_W'($urandom_range(0, 2));
  endtask

  // Upstream requests that must be ignored while a sequence runs.
  task automatic poke();
    wb_csr_valid = 1'b1;
    wb_csr_rd    = CSR_W'($urandom_range(0, 3));
    wb_csr_data  = $urandom;
    trap_req     = 1'b1;
    trap_pc      = $urandom;
    mret_req     = 1'b1;
  endtask

  // Check one cycle's outputs at the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input logic ewe, input logic [CSR_W-1:0] ewa,
                      input logic [31:0] ewd, input logic ebusy, input logic erv,
                      input logic [31:0] erpc);
    @(negedge clk);
    check({tag, ".wr_en"}, 32'(csr_wr_en), 32'(ewe));
    if (ewe) begin
      check({tag, ".wr_addr"}, 32'(csr_wr_addr), 32'(ewa));
      check({tag, ".wr_data"}, csr_wr_data, ewd);
    end
    check({tag, ".busy"}, 32'(busy), 32'(ebusy));
    check({tag, ".redir_v"}, 32'(redirect_valid), 32'(erv));
    check({tag, ".redir_pc"}, redirect_pc, erpc);
    if (ebusy) check({tag, ".idu_data"}, idu_csr_rs_data, 32'h0);
    else       check({tag, ".idu_data"}, idu_csr_rs_data, ref_csr[idu_csr_rs[1:0]]);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic wb_write(input int idx, input logic [31:0] data);
    wb_csr_valid = 1'b1;
    wb_csr_rd    = CSR_W'(idx);
    wb_csr_data  = data;
    step("wb", 1'b1, CSR_W'(idx), data, 1'b0, 1'b0, last_rpc);
    ref_csr[idx] = data;
  endtask

  task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause,
                          input logic also_mret, input logic noise, input logic rnd_wb);
    logic        wb;
    logic [1:0]  wi;
    logic [31:0] wd, ms, vec;
    wb = rnd_wb & 1'($urandom_range(0, 1));
    wi = 2'($urandom_range(0, 3));
    wd = $urandom;
    trap_req = 1'b1; trap_pc = pc; trap_cause = cause; mret_req = also_mret;
    wb_csr_valid = wb; wb_csr_rd = CSR_W'(wi); wb_csr_data = wd;
    step("trap.c0", wb, CSR_W'(wi), wd, 1'b0, 1'b0, last_rpc);
    if (wb) ref_csr[wi] = wd;
    if (noise) poke();
    step("trap.c1", 1'b1, CSR_W'(IDX_MEPC), pc, 1'b1, 1'b0, last_rpc);
    ref_csr[IDX_MEPC] = pc;
    if (noise) poke();
    step("trap.c2", 1'b1, CSR_W'(IDX_MCAUSE), cause, 1'b1, 1'b0, last_rpc);
    ref_csr[IDX_MCAUSE] = cause;
    ms = trap_ms(ref_csr[IDX_MSTATUS]);
    if (noise) poke();
    step("trap.c3", 1'b1, CSR_W'(IDX_MSTATUS), ms, 1'b1, 1'b0, last_rpc);
    ref_csr[IDX_MSTATUS] = ms;
    vec = ref_csr[IDX_MTVEC] & ~32'h3;
    if (noise) poke();
    step("trap.c4", 1'b0, '0, '0, 1'b1, 1'b1, vec);
    last_rpc = vec;
    step("trap.c5", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
  endtask

  task automatic run_mret(input logic noise, input logic rnd_wb);
    logic        wb;
    logic [1:0]  wi;
    logic [31:0] wd, ms, epc;
    wb = rnd_wb & 1'($urandom_range(0, 1));
    wi = 2'($urandom_range(0, 3));
    wd = $urandom;
    mret_req = 1'b1;
    wb_csr_valid = wb; wb_csr_rd = CSR_W'(wi); wb_csr_data = wd;
    step("mret.c0", wb, CSR_W'(wi), wd, 1'b0, 1'b0, last_rpc);
    if (wb) ref_csr[wi] = wd;
    ms = mret_ms(ref_csr[IDX_MSTATUS]);
    if (noise) poke();
    step("mret.c1", 1'b1, CSR_W'(IDX_MSTATUS), ms, 1'b1, 1'b0, last_rpc);
    ref_csr[IDX_MSTATUS] = ms;
    epc = ref_csr[IDX_MEPC];
    if (noise) poke();
    step("mret.c2", 1'b0, '0, '0, 1'b1, 1'b1, epc);
    last_rpc = epc;
    step("mret.c3", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    rst = 1'b1; wb_csr_rd = '0; wb_csr_data = '0; trap_pc = '0; trap_cause = '0;
    clear_inputs();
    idu_csr_rs = '0;
    last_rpc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then an ordinary WBU write passes straight through.
    step("reset", 1'b0, '0, '0, 1'b0, 1'b0, 32'h0);
    wb_write(IDX_MTVEC, 32'h8000_0400);
    wb_write(IDX_MSTATUS, 32'h0000_1808);
    wb_write(IDX_MEPC, 32'h0);
    wb_write(IDX_MCAUSE, 32'h0);
    wb_write(IDX_MTVEC, 32'h8000_0401);

    // Directed trap from the worked example.
    run_trap(32'h8000_0100, 32'hb, 1'b0, 1'b0, 1'b0);
    check("t2.mstatus", csr_file[IDX_MSTATUS], 32'h0000_1880);
    check("t2.mepc", csr_file[IDX_MEPC], 32'h8000_0100);
    check("t2.redirect", redirect_pc, 32'h8000_0400);

    // Directed mret.
    wb_write(IDX_MEPC, 32'h8000_0104);
    run_mret(1'b0, 1'b0);
    check("t3.mstatus", csr_file[IDX_MSTATUS], 32'h0000_1888);
    check("t3.redirect", redirect_pc, 32'h8000_0104);

    // Simultaneous trap and mret: trap wins.
    run_trap($urandom & ~32'h3, $urandom, 1'b1, 1'b0, 1'b0);
    // Requests and writes during a trap are ignored.
    run_trap($urandom & ~32'h3, $urandom, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a trap.
    pc = $urandom & ~32'h3;
    trap_req = 1'b1; trap_pc = pc; trap_cause = 32'h7;
    step("rst_trap.c0", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
    step("rst_trap.c1", 1'b1, CSR_W'(IDX_MEPC), pc, 1'b1, 1'b0, last_rpc);
    ref_csr[IDX_MEPC] = pc;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    last_rpc = '0;
    step("rst_trap.c3", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
    step("rst_trap.c4", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
    check("rst_trap.mstatus", csr_file[IDX_MSTATUS], ref_csr[IDX_MSTATUS]);
    run_trap($urandom & ~32'h3, $urandom, 1'b0, 1'b0, 1'b0);

    // Randomized mix of sequences, WBU traffic and ignored requests.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: wb_write(int'($urandom_range(0, 3)), $urandom);
        1: run_trap($urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1);
        2: run_mret(1'($urandom_range(0, 1)), 1'b1);
        default: step("idle", 1'b0, '0, '0, 1'b0, 1'b0, last_rpc);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
